ps2_key_tracker: RTL and testbench

Downstream consumer of the PS/2 scancode receiver: takes each decoded 10-bit scancode word `{extended, break, code[7:0]}` and its one-cycle ready pulse, and maps the twelve game keys to a held-key bitmap. It also generates press/release edge pulses and queues edge events in a small show-ahead FIFO for the game-control logic. Auto-repeat (typematic) makes and stray breaks are filtered out, so consumers see exactly one press and one release per physical keystroke.

---
 rtl/ps2_key_tracker.sv | 138 +++++++++++++
 tb/tb_ps2_key_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// Maps decoded PS/2 scancode words onto a 12-key held bitmap, emits press/release
// pulses and queues edge events in a show-ahead FIFO with a sticky overflow flag.
module ps2_key_tracker #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kb_ready,
  input  logic [9:0]  kb_data,
  input  logic        clear_all,
  output logic [11:0] key_state,
  output logic [11:0] key_press,
  output logic [11:0] key_release,
  output logic        evt_valid,
  output logic [4:0]  evt_data,
  input  logic        evt_ready,
  output logic        evt_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  // Returns {hit, index}; the extended flag is part of the match key.
  function automatic logic [4:0] map_key(input logic [8:0] key);
    logic [4:0] res;
    case (key)
      9'h01D:  res = 5'h10;
      9'h01B:  res = 5'h11;
      9'h01C:  res = 5'h12;
      9'h023:  res = 5'h13;
      9'h029:  res = 5'h14;
      9'h175:  res = 5'h15;
      9'h172:  res = 5'h16;
      9'h16B:  res = 5'h17;
      9'h174:  res = 5'h18;
      9'h05A:  res = 5'h19;
      9'h076:  res = 5'h1A;
      9'h04D:  res = 5'h1B;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  logic [11:0]   key_state_r;
  logic [11:0]   key_press_r;
  logic [11:0]   key_release_r;
  logic          overflow_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic [4:0]    mem_r [FIFO_DEPTH];

  logic [4:0]  lookup_s;
  logic [3:0]  idx_s;
  logic [11:0] onehot_s;
  logic        held_s;
  logic        make_s;
  logic        brk_s;
  logic        push_s;
  logic        pop_s;
  logic        full_s;
  logic        accept_s;
  logic [PW:0] count_nxt_s;

  // Decode the incoming word and work out FIFO push/pop for this cycle.
  always_comb begin
    lookup_s = map_key({kb_data[9], kb_data[7:0]});
    idx_s    = lookup_s[3:0];
    onehot_s = 12'd1 << idx_s;
    held_s   = |(key_state_r & onehot_s);
    make_s   = kb_ready & lookup_s[4] & ~kb_data[8] & ~held_s;
    brk_s    = kb_ready & lookup_s[4] & kb_data[8] & held_s;
    push_s   = make_s | brk_s;
    pop_s    = (count_r != '0) & evt_ready;
    full_s   = (count_r == DEPTH_C);
    // A pop in the same cycle frees the slot the push needs.
    accept_s = push_s & (~full_s | pop_s);
    case ({accept_s, pop_s})
      2'b10:   count_nxt_s = count_r + (PW + 1)'(1);
      2'b01:   count_nxt_s = count_r - (PW + 1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Key bitmap, pulses, FIFO pointers and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state_r   <= 12'd0;
      key_press_r   <= 12'd0;
      key_release_r <= 12'd0;
      overflow_r    <= 1'b0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
    end else if (clear_all) begin
      key_state_r   <= 12'd0;
      key_press_r   <= 12'd0;
      key_release_r <= 12'd0;
      overflow_r    <= 1'b0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
    end else begin
      key_press_r   <= make_s ? onehot_s : 12'd0;
      key_release_r <= brk_s ? onehot_s : 12'd0;
      if (make_s) begin
        key_state_r <= key_state_r | onehot_s;
      end else if (brk_s) begin
        key_state_r <= key_state_r & ~onehot_s;
      end
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (push_s & ~accept_s) begin
        overflow_r <= 1'b1;
      end
      count_r <= count_nxt_s;
    end
  end

  // Event storage; contents are only observed while the count says they are live.
  always_ff @(posedge clk) begin
    if (accept_s & ~clear_all) begin
      mem_r[wr_ptr_r] <= {brk_s, idx_s};
    end
  end

  assign key_state    = key_state_r;
  assign key_press    = key_press_r;
  assign key_release  = key_release_r;
  assign evt_overflow = overflow_r;
  assign evt_valid    = (count_r != '0);
  assign evt_data     = evt_valid ? mem_r[rd_ptr_r] : 5'd0;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_ps2_key_tracker;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kb_ready = 1'b0;
  logic [9:0]  kb_data = 10'd0;
  logic        clear_all = 1'b0;
  logic        evt_ready = 1'b0;
  logic [11:0] key_state, key_press, key_release;
  logic        evt_valid, evt_overflow;
  logic [4:0]  evt_data;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [8:0]  keys [12] = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h029, 9'h175,
                             9'h172, 9'h16B, 9'h174, 9'h05A, 9'h076, 9'h04D};
  int          keymap [int];
  bit   [11:0] m_held;
  bit   [11:0] m_press;
  bit   [11:0] m_rel;
  bit          m_ovf;
  bit   [4:0]  m_q [$];

  ps2_key_tracker #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .kb_ready(kb_ready), .kb_data(kb_data),
    .clear_all(clear_all), .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ready(evt_ready), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  function automatic bit [4:0] exp_data();
    return (m_q.size() > 0) ? m_q[0] : 5'd0;
  endfunction

  task automatic model_reset();
    m_held = '0; m_press = '0; m_rel = '0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [9:0] d, input logic r, input logic c);
    int key;
    int idx;
    bit have_evt;
    bit [4:0] evt;
    m_press = '0;
    m_rel = '0;
    if (c) begin
      model_reset();
      return;
    end
    if (r && m_q.size() > 0) void'(m_q.pop_front());
    have_evt = 1'b0;
    key = {d[9], d[7:0]};
    if (v && keymap.exists(key)) begin
      idx = keymap[key];
      if (!d[8] && !m_held[idx]) begin
        m_held[idx] = 1'b1; m_press[idx] = 1'b1;
        evt = {1'b0, 4'(idx)}; have_evt = 1'b1;
      end else if (d[8] && m_held[idx]) begin
        m_held[idx] = 1'b0; m_rel[idx] = 1'b1;
        evt = {1'b1, 4'(idx)}; have_evt = 1'b1;
      end
    end
    if (have_evt) begin
      if (m_q.size() < DEPTH) m_q.push_back(evt);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic cycle(input logic v, input logic [9:0] d, input logic r, input logic c);
    kb_ready = v; kb_data = d; evt_ready = r; clear_all = c;
    model_step(v, d, r, c);
    @(posedge clk); #1;
    kb_ready = 1'b0; evt_ready = 1'b0; clear_all = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({key_state, key_press, key_release, evt_valid, evt_data, evt_overflow} !== 43'd0) begin
      n_err++;
      $display("FAIL reset_outputs got ks=%h kp=%h kr=%h v=%b d=%h o=%b required all 0",
               key_state, key_press, key_release, evt_valid, evt_data, evt_overflow);
    end
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    cycle(1'b1, 10'h01D, 1'b0, 1'b0);
    n_cmp++; if (key_state !== 12'h001) begin n_err++; $display("FAIL basic_state got %h required 001", key_state); end
    n_cmp++; if (key_press !== 12'h001) begin n_err++; $display("FAIL basic_press got %h required 001", key_press); end
    n_cmp++; if (evt_valid !== 1'b1 || evt_data !== 5'h00) begin n_err++; $display("FAIL basic_evt got v=%b d=%h required v=1 d=00", evt_valid, evt_data); end
    cycle(1'b0, 10'h000, 1'b0, 1'b0);
    n_cmp++; if (key_press !== 12'h000) begin n_err++; $display("FAIL basic_press_width got %h required 000", key_press); end
    cycle(1'b1, 10'h11D, 1'b0, 1'b0);
    n_cmp++; if (key_state !== 12'h000 || key_release !== 12'h001) begin n_err++; $display("FAIL basic_break got ks=%h kr=%h required ks=000 kr=001", key_state, key_release); end
    cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_cmp++; if (evt_valid !== 1'b1 || evt_data !== 5'h10) begin n_err++; $display("FAIL basic_second_evt got v=%b d=%h required v=1 d=10", evt_valid, evt_data); end
    cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty got v=%b required 0", evt_valid); end
  endtask

  task automatic test_typematic();
    cycle(1'b0, 10'h000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 10'h029, 1'b0, 1'b0);
      n_cmp++; if (key_state[4] !== 1'b1) begin n_err++; $display("FAIL typematic_held[%0d] got %b required 1", i, key_state[4]); end
      n_cmp++; if (key_press !== ((i == 0) ? 12'h010 : 12'h000)) begin n_err++; $display("FAIL typematic_press[%0d] got %h", i, key_press); end
    end
    cycle(1'b1, 10'h129, 1'b0, 1'b0);
    n_cmp++; if (evt_data !== 5'h04) begin n_err++; $display("FAIL typematic_evt0 got %h required 04", evt_data); end
    cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_cmp++; if (evt_valid !== 1'b1 || evt_data !== 5'h14) begin n_err++; $display("FAIL typematic_evt1 got v=%b d=%h required v=1 d=14", evt_valid, evt_data); end
    cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL typematic_count got v=%b required 0", evt_valid); end
  endtask

  task automatic test_extended();
    cycle(1'b0, 10'h000, 1'b0, 1'b1);
    cycle(1'b1, 10'h275, 1'b0, 1'b0);
    n_cmp++; if (key_state !== 12'h020 || evt_data !== 5'h05) begin n_err++; $display("FAIL ext_up got ks=%h d=%h required ks=020 d=05", key_state, evt_data); end
    cycle(1'b1, 10'h075, 1'b0, 1'b0);
    cycle(1'b1, 10'h012, 1'b0, 1'b0);
    n_cmp++; if (key_state !== 12'h020 || key_press !== 12'h000) begin n_err++; $display("FAIL ext_unmapped got ks=%h kp=%h required ks=020 kp=000", key_state, key_press); end
    cycle(1'b1, 10'h372, 1'b0, 1'b0);
    n_cmp++; if (key_release !== 12'h000 || key_state !== 12'h020) begin n_err++; $display("FAIL ext_stray_break got kr=%h ks=%h required kr=000 ks=020", key_release, key_state); end
    cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL ext_single_evt got v=%b required 0", evt_valid); end
  endtask

  task automatic test_overflow();
    cycle(1'b0, 10'h000, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (evt_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early[%0d] got %b required 0", i, evt_overflow); end
      cycle(1'b1, (i % 2 == 0) ? 10'h01D : 10'h11D, 1'b0, 1'b0);
    end
    n_cmp++; if (evt_overflow !== 1'b1 || key_state !== 12'h001) begin n_err++; $display("FAIL ovf_set got o=%b ks=%h required o=1 ks=001", evt_overflow, key_state); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (evt_valid !== 1'b1 || evt_data !== ((i % 2 == 0) ? 5'h00 : 5'h10)) begin n_err++; $display("FAIL ovf_drain[%0d] got v=%b d=%h", i, evt_valid, evt_data); end
      cycle(1'b0, 10'h000, 1'b1, 1'b0);
    end
    n_cmp++; if (evt_valid !== 1'b0 || evt_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_after_drain got v=%b o=%b required v=0 o=1", evt_valid, evt_overflow); end
    cycle(1'b0, 10'h000, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, (i % 2 == 0) ? 10'h01D : 10'h11D, (i == 8), 1'b0);
    n_cmp++; if (evt_overflow !== 1'b0 || evt_data !== 5'h10 || key_state !== 12'h001) begin n_err++; $display("FAIL ovf_pop_same_cycle got o=%b d=%h ks=%h required o=0 d=10 ks=001", evt_overflow, evt_data, key_state); end
  endtask

  task automatic test_drain();
    logic [4:0] want [3] = '{5'h05, 5'h07, 5'h15};
    cycle(1'b0, 10'h000, 1'b0, 1'b1);
    cycle(1'b1, 10'h275, 1'b0, 1'b0);
    cycle(1'b1, 10'h26B, 1'b0, 1'b0);
    cycle(1'b1, 10'h375, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (evt_valid !== 1'b1 || evt_data !== want[i]) begin n_err++; $display("FAIL drain[%0d] got v=%b d=%h required v=1 d=%h", i, evt_valid, evt_data, want[i]); end
      cycle(1'b0, 10'h000, 1'b1, 1'b0);
    end
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got v=%b required 0", evt_valid); end
  endtask

  task automatic test_clear();
    cycle(1'b0, 10'h000, 1'b0, 1'b1);
    cycle(1'b1, 10'h01D, 1'b0, 1'b0);
    cycle(1'b1, 10'h274, 1'b0, 1'b0);
    cycle(1'b1, 10'h029, 1'b0, 1'b0);
    n_cmp++; if (key_state !== 12'h111) begin n_err++; $display("FAIL clear_setup got %h required 111", key_state); end
    cycle(1'b1, 10'h01C, 1'b0, 1'b1);
    n_cmp++; if (key_state !== 12'h000 || evt_valid !== 1'b0) begin n_err++; $display("FAIL clear_state got ks=%h v=%b required ks=000 v=0", key_state, evt_valid); end
    n_cmp++; if (key_press !== 12'h000 || key_release !== 12'h000) begin n_err++; $display("FAIL clear_pulses got kp=%h kr=%h required 000", key_press, key_release); end
    cycle(1'b0, 10'h000, 1'b0, 1'b0);
    n_cmp++; if (key_state !== 12'h000 || evt_valid !== 1'b0) begin n_err++; $display("FAIL clear_hold got ks=%h v=%b required ks=000 v=0", key_state, evt_valid); end
  endtask

  task automatic test_random();
    logic [8:0] k;
    logic [9:0] d;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) != 0) begin
        k = keys[$urandom_range(11)];
        d = {k[8], 1'($urandom_range(1)), k[7:0]};
      end else begin
        d = 10'($urandom);
      end
      cycle(1'($urandom_range(1)), d, ($urandom_range(9) < 3), ($urandom_range(59) == 0));
      n_cmp++; if (key_state !== m_held) begin n_err++; $display("FAIL rand_state[%0d] got %h required %h", i, key_state, m_held); end
      n_cmp++; if (key_press !== m_press || key_release !== m_rel) begin n_err++; $display("FAIL rand_pulse[%0d] got kp=%h kr=%h required kp=%h kr=%h", i, key_press, key_release, m_press, m_rel); end
      n_cmp++; if (evt_valid !== (m_q.size() > 0) || evt_data !== exp_data()) begin n_err++; $display("FAIL rand_evt[%0d] got v=%b d=%h required v=%b d=%h", i, evt_valid, evt_data, (m_q.size() > 0), exp_data()); end
      n_cmp++; if (evt_overflow !== m_ovf) begin n_err++; $display("FAIL rand_ovf[%0d] got %b required %b", i, evt_overflow, m_ovf); end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 10'h000, 1'b0, 1'b1);
    cycle(1'b1, 10'h01D, 1'b0, 1'b0);
    n_cmp++; if (key_state !== 12'h001) begin n_err++; $display("FAIL arst_setup got %h required 001", key_state); end
    kb_ready = 1'b1; kb_data = 10'h01B;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({key_state, key_press, key_release, evt_valid, evt_data, evt_overflow} !== 43'd0) begin n_err++; $display("FAIL arst_immediate got ks=%h v=%b d=%h required all 0", key_state, evt_valid, evt_data); end
    @(posedge clk); #1;
    kb_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_cmp++; if (key_state !== 12'h000 || evt_valid !== 1'b0) begin n_err++; $display("FAIL arst_lost_word got ks=%h v=%b required ks=000 v=0", key_state, evt_valid); end
  endtask

  initial begin
    for (int i = 0; i < 12; i++) keymap[int'(keys[i])] = i;
    model_reset();
    test_reset();
    test_basic();
    test_typematic();
    test_extended();
    test_overflow();
    test_drain();
    test_clear();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
